// File: rtl/imem_loader.sv
// Purpose : loads a length-prefixed big-endian byte stream into instruction memory as 32-bit words.
// Latency : mem_we pulses the cycle after the 4th byte of a word is accepted; done pulses one cycle after the last write.
// Backpres: byte_ready is low in IDLE, WRITE and FIN; byte_valid low in accepting states stalls with no state change.
//
// Ports:
//   clk, rst_n                  single clock, asynchronous active-low reset
//   start                       begin a load session (sampled in IDLE only)
//   byte_valid/byte_ready/byte_data  byte stream handshake: 2 length bytes (MSB first), then N*4 data bytes
//   mem_we/mem_addr/mem_wdata   one-cycle write port; address/data hold between writes
//   busy, done, err             session status; err marks a length larger than DEPTH_WORDS
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q;
  logic [15:0] word_cnt_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] addr_q;
  logic [31:0] asm_q;
  logic [31:0] len_n;       // word count as it completes on the LEN_LO transfer
  logic [31:0] asm_next;
  logic        len_over;

  // Depends on state only, so handshake logic never loops back through it.
  assign byte_ready = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA);

  assign len_n    = {16'd0, len_q[15:8], byte_data};
  assign len_over = (len_n > DEPTH_WORDS);
  assign asm_next = {asm_q[23:0], byte_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    mem_we  = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = LEN_HI;
      end
      LEN_HI: begin
        if (byte_valid) state_d = LEN_LO;
      end
      LEN_LO: begin
        if (byte_valid) begin
          if (len_n == 32'd0 || len_over) state_d = FIN;
          else                            state_d = DATA;
        end
      end
      DATA: begin
        if (byte_valid && byte_cnt_q == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        // word_cnt_q is incremented on this same edge, so compare the post-increment value.
        if (word_cnt_q + 16'd1 == len_q) state_d = FIN;
        else                             state_d = DATA;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      asm_q      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            err        <= 1'b0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            addr_q     <= BASE_ADDR;
          end
        end
        LEN_HI: begin
          if (byte_valid) len_q[15:8] <= byte_data;
        end
        LEN_LO: begin
          if (byte_valid) begin
            len_q[7:0] <= byte_data;
            if (len_over) err <= 1'b1;
          end
        end
        DATA: begin
          if (byte_valid) begin
            asm_q      <= asm_next;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            // Output registers load only when a word completes, so they hold between writes
            // and are exactly addr/word during the WRITE cycle.
            if (byte_cnt_q == 2'd3) begin
              mem_addr  <= addr_q;
              mem_wdata <= asm_next;
            end
          end
        end
        WRITE: begin
          addr_q     <= addr_q + 32'd4;
          word_cnt_q <= word_cnt_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;

  logic        ready0, we0, busy0, done0, err0;
  logic [31:0] addr0, wdata0;
  logic        ready1, we1, busy1, done1, err1;
  logic [31:0] addr1, wdata1;

  int errors = 0;
  int checks = 0;

  logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];
  int done_cnt0 = 0, done_cnt1 = 0, overlap0 = 0;
  logic [7:0] stim [0:15];

  always #5 clk = ~clk;

  imem_loader #(.DEPTH_WORDS(1024), .BASE_ADDR(32'd0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(ready0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
    .busy(busy0), .done(done0), .err(err0));

  imem_loader #(.DEPTH_WORDS(1024), .BASE_ADDR(32'd20)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(ready1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
    .busy(busy1), .done(done1), .err(err1));

  // Write/done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (we0) begin wa0.push_back(addr0); wd0.push_back(wdata0); end
    if (we1) begin wa1.push_back(addr1); wd1.push_back(wdata1); end
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
    if (we0 && ready0) overlap0++;
  end

  task automatic clear_logs();
    wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
    done_cnt0 = 0; done_cnt1 = 0; overlap0 = 0;
  endtask

  task automatic load_stim(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) stim[i] = v[8*(n-1-i) +: 8];
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one byte until it is accepted; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit got;
    got = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = ready0;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_byte: byte %h not accepted within 20 cycles", b);
    end
    if (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_stream(input int n, input bit gap);
    for (int i = 0; i < n; i++) send_byte(stim[i], gap);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 20 && !idle; i++) begin
      @(negedge clk);
      idle = !busy0;
    end
    @(posedge clk); #1;
    if (!idle) begin
      checks++; errors++;
      $display("FAIL wait_idle: busy still high after 20 cycles");
    end
  endtask

  task automatic check_two_writes(input string nm, input logic [31:0] a0, input logic [31:0] d0,
                                  input logic [31:0] a1, input logic [31:0] d1);
    checks++;
    if (wa0.size() !== 2) begin
      errors++; $display("FAIL %s write count: got %0d want 2", nm, wa0.size());
    end else begin
      checks++;
      if (wa0[0] !== a0 || wd0[0] !== d0) begin
        errors++; $display("FAIL %s write0: got %h/%h want %h/%h", nm, wa0[0], wd0[0], a0, d0);
      end
      checks++;
      if (wa0[1] !== a1 || wd0[1] !== d1) begin
        errors++; $display("FAIL %s write1: got %h/%h want %h/%h", nm, wa0[1], wd0[1], a1, d1);
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL reset byte_ready: got %b want 0", ready0); end
    checks++; if (we0 !== 1'b0)    begin errors++; $display("FAIL reset mem_we: got %b want 0", we0); end
    checks++; if (addr0 !== 32'h0) begin errors++; $display("FAIL reset mem_addr: got %h want 0", addr0); end
    checks++; if (wdata0 !== 32'h0) begin errors++; $display("FAIL reset mem_wdata: got %h want 0", wdata0); end
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0) begin
      errors++; $display("FAIL reset status: busy/done/err got %b%b%b want 000", busy0, done0, err0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL idle_no_start busy: got %b want 0", busy0); end
  endtask

  task automatic test_basic();
    clear_logs();
    load_stim(128'h00022108000821290009, 10);
    pulse_start();
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL basic busy after start: got %b want 1", busy0); end
    for (int i = 0; i < 10; i++) begin
      send_byte(stim[i], 1'b0);
      if (i == 5) begin
        checks++;
        if (we0 !== 1'b1 || addr0 !== 32'h0 || wdata0 !== 32'h21080008) begin
          errors++; $display("FAIL basic write timing: we/addr/data got %b/%h/%h want 1/0/21080008", we0, addr0, wdata0);
        end
      end
    end
    wait_idle();
    check_two_writes("basic", 32'h0, 32'h21080008, 32'h4, 32'h21290009);
    checks++; if (done_cnt0 !== 1) begin errors++; $display("FAIL basic done pulses: got %0d want 1", done_cnt0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL basic err: got %b want 0", err0); end
    checks++; if (addr0 !== 32'h4 || wdata0 !== 32'h21290009) begin
      errors++; $display("FAIL basic hold: got %h/%h want 4/21290009", addr0, wdata0);
    end
  endtask

  task automatic test_gaps();
    clear_logs();
    load_stim(128'h00022108000821290009, 10);
    pulse_start();
    send_stream(10, 1'b1);
    wait_idle();
    check_two_writes("gaps", 32'h0, 32'h21080008, 32'h4, 32'h21290009);
    checks++; if (overlap0 !== 0) begin errors++; $display("FAIL gaps we_while_ready: got %0d cycles want 0", overlap0); end
    checks++; if (done_cnt0 !== 1) begin errors++; $display("FAIL gaps done pulses: got %0d want 1", done_cnt0); end
  endtask

  task automatic test_zero_len();
    clear_logs();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL zero_len done after LEN_LO: got %b want 1", done0); end
    @(posedge clk); #1;
    checks++; if (done0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL zero_len back to idle: done/busy got %b%b want 00", done0, busy0);
    end
    checks++; if (wa0.size() !== 0) begin errors++; $display("FAIL zero_len writes: got %0d want 0", wa0.size()); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL zero_len err: got %b want 0", err0); end
  endtask

  task automatic test_too_long();
    clear_logs();
    pulse_start();
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    checks++; if (err0 !== 1'b1 || done0 !== 1'b1) begin
      errors++; $display("FAIL too_long err/done: got %b%b want 11", err0, done0);
    end
    wait_idle();
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL too_long err held: got %b want 1", err0); end
    checks++; if (wa0.size() !== 0) begin errors++; $display("FAIL too_long writes: got %0d want 0", wa0.size()); end
    pulse_start();
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL too_long err clear: got %b want 0", err0); end
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_idle();
  endtask

  task automatic test_reset_mid();
    clear_logs();
    load_stim(128'h00018D280018, 6);
    pulse_start();
    send_stream(4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy0 !== 1'b0 || ready0 !== 1'b0 || we0 !== 1'b0) begin
      errors++; $display("FAIL reset_mid status: busy/ready/we got %b%b%b want 000", busy0, ready0, we0);
    end
    checks++; if (addr0 !== 32'h0 || wdata0 !== 32'h0) begin
      errors++; $display("FAIL reset_mid mem regs: got %h/%h want 0/0", addr0, wdata0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (wa0.size() !== 0) begin errors++; $display("FAIL reset_mid stray write: got %0d want 0", wa0.size()); end
    pulse_start();
    send_stream(6, 1'b0);
    wait_idle();
    checks++;
    if (wa0.size() !== 1) begin
      errors++; $display("FAIL reset_mid write count: got %0d want 1", wa0.size());
    end else begin
      checks++;
      if (wa0[0] !== 32'h0 || wd0[0] !== 32'h8D280018) begin
        errors++; $display("FAIL reset_mid write: got %h/%h want 0/8d280018", wa0[0], wd0[0]);
      end
    end
  endtask

  task automatic test_base_addr();
    clear_logs();
    load_stim(128'h00028D280018AD680018, 10);
    pulse_start();
    send_stream(4, 1'b0);
    start = 1'b1;
    send_byte(stim[4], 1'b0);
    start = 1'b0;
    for (int i = 5; i < 10; i++) send_byte(stim[i], 1'b0);
    wait_idle();
    repeat (2) @(posedge clk); #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL base busy after session: got %b want 0", busy1); end
    checks++; if (done_cnt1 !== 1) begin errors++; $display("FAIL base done pulses: got %0d want 1", done_cnt1); end
    checks++;
    if (wa1.size() !== 2) begin
      errors++; $display("FAIL base write count: got %0d want 2", wa1.size());
    end else begin
      checks++;
      if (wa1[0] !== 32'h14 || wd1[0] !== 32'h8D280018) begin
        errors++; $display("FAIL base write0: got %h/%h want 14/8d280018", wa1[0], wd1[0]);
      end
      checks++;
      if (wa1[1] !== 32'h18 || wd1[1] !== 32'hAD680018) begin
        errors++; $display("FAIL base write1: got %h/%h want 18/ad680018", wa1[1], wd1[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    start = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL b2b FIN done: got %b want 1", done0); end
    @(posedge clk); #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b idle cycle busy: got %b want 0", busy0); end
    @(posedge clk); #1;
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL b2b restart busy: got %b want 1", busy0); end
    start = 1'b0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_idle();
    checks++; if (done_cnt0 !== 2) begin errors++; $display("FAIL b2b done pulses: got %0d want 2", done_cnt0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_zero_len();
    test_too_long();
    test_reset_mid();
    test_base_addr();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
